lsu_align: RTL and testbench
============================

LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter: ADDR_W, 32, request/memory address width.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: ReqValid  in  1  core request valid.
REQ-005 Port: ReqReady  out  1  unit can accept a request.
REQ-006 Port: ReqWe  in  1  1 = store, 0 = load.
REQ-007 Port: ReqOp  in  2  size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-008 Port: ReqSigned  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-009 Port: ReqAddr  in  ADDR_W  byte address.
REQ-010 Port: ReqWData  in  32  store data, right-justified.
REQ-011 Port: MemValid  out  1  memory request valid.
REQ-012 Port: MemReady  in  1  memory accepts request.
REQ-013 Port: MemWe  out  1  memory write.
REQ-014 Port: MemAddr  out  ADDR_W  word address, bits [1:0] = 00.
REQ-015 Port: MemBE  out  4  byte enables, bit k = byte lane k.
REQ-016 Port: MemWData  out  32  lane-replicated store data.
REQ-017 Port: MemRValid  in  1  read data valid.
REQ-018 Port: MemRData  in  32  read data word.
REQ-019 Port: RspValid  out  1  one-cycle completion pulse.
REQ-020 Port: RspData  out  32  extended load result; 0 for stores.
REQ-021 Port: RspExc  out  1  address-misalignment flag.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, RSP; ReqReady = 1 only in IDLE.
REQ-023 IDLE: on ReqValid, latch We/Op/Signed/Addr/WData, go REQ (misaligned with macro: go RSP).
REQ-024 REQ: MemValid = 1, outputs held stable until MemReady; on MemReady, store -> RSP, load -> WAIT.
REQ-025 WAIT: on MemRValid, register extracted result, go RSP; MemRValid outside WAIT is ignored.
REQ-026 RSP: RspValid = 1 for exactly one cycle, then IDLE.
REQ-027 Latency with MemReady and MemRValid immediate: accept at T, MemValid at T+1, store RspValid at T+2, load RspValid at T+3.
REQ-028 Lanes little-endian: offset k = ReqAddr[1:0] selects bits [8k+7:8k].
REQ-029 Store byte: MemWData = {4{WData[7:0]}}, MemBE = 0001 << k.
REQ-030 Store half: MemWData = {2{WData[15:0]}}, MemBE = 1100 if Addr[1] else 0011.
REQ-031 Store word: MemWData = WData, MemBE = 1111.
REQ-032 Load: MemBE = 1111; the selected byte/half is extended per ReqSigned to 32 bits; word is passed unchanged.
REQ-033 Misaligned: half with Addr[0] = 1, or word with Addr[1:0] != 00.
REQ-034 Outputs driven only in their states; MemValid, MemWe, MemBE are 0 outside REQ.

Reset
REQ-035 Reset forces IDLE; MemValid, MemWe, RspValid, RspExc = 0; MemBE, MemAddr, MemWData, RspData = 0.
REQ-036 Reset mid-operation abandons the transaction with no RspValid; MemRValid arriving after reset is ignored.

Configuration
REQ-037 Macro LSU_ADDR_EXC_EN defined: misaligned request issues no memory access and goes to RSP with RspExc = 1 and RspData = 0.
REQ-038 LSU_ADDR_EXC_EN undefined: RspExc is tied 0; misaligned half ignores Addr[0], misaligned word ignores Addr[1:0].

Structure
REQ-039 Shared package lsu_pkg holds the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state enum.
REQ-040 Sub-module lsu_load_ext is combinational: (word, offset, size, signed) -> 32-bit result; instantiated once.

Verification
REQ-041 Store byte 0xA5 to addr 0x1002 -> MemAddr 0x1000, MemBE 0100, MemWData 0xA5A5A5A5, RspValid at T+2.
REQ-042 Load half signed, addr 0x2002, MemRData 0x80017FFF -> RspData 0xFFFF8001; unsigned -> 0x00008001.
REQ-043 Load byte signed, addr 0x3001, MemRData 0x00008000 -> RspData 0xFFFFFF80, RspValid at T+3.
REQ-044 MemReady held low 5 cycles -> MemValid, MemAddr, MemBE, MemWData stable all 5 cycles, ReqReady = 0.
REQ-045 Word load at 0x4001: with the macro, RspExc = 1, RspData = 0, MemValid never asserted; without it, MemAddr = 0x4000.
REQ-046 Reset asserted in WAIT, then MemRValid pulses -> no RspValid; the FSM stays in IDLE with ReqReady = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared size encodings, FSM state type and alignment helper
//               for the load/store alignment unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Reserved size 11 behaves as a word, including its alignment rule.
  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      SZ_HALF: mis = off[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_ext.sv
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational load-data lane select and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_i[{offset_i, 3'b000} +: 8];
    // Only offset bit 1 picks the half, so an odd half address rounds down.
    sel_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & sel_byte[7]}}, sel_byte};
      SZ_HALF: result_o = {{16{signed_i & sel_half[15]}}, sel_half};
      default: result_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Load/store alignment unit between core and word memory.
//               Define LSU_ADDR_EXC_EN to trap misaligned accesses (RspExc).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWe,
  input  logic [1:0]        ReqOp,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              MemValid,
  input  logic              MemReady,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemBE,
  output logic [31:0]       MemWData,
  input  logic              MemRValid,
  input  logic [31:0]       MemRData,
  output logic              RspValid,
  output logic [31:0]       RspData,
  output logic              RspExc
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        op_q, op_d;
  logic              sgn_q, sgn_d;
  logic              exc_q, exc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rsp_q, rsp_d;

  logic              req_mis;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ext_data;

`ifdef LSU_ADDR_EXC_EN
  assign req_mis = is_misaligned(ReqOp, ReqAddr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  lsu_load_ext u_load_ext (
    .word_i   (MemRData),
    .offset_i (addr_q[1:0]),
    .size_i   (op_q),
    .signed_i (sgn_q),
    .result_o (ext_data)
  );

  // Store lanes: replicate data across the word and enable only the target bytes.
  always_comb begin
    case (op_q)
      SZ_BYTE: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    exc_d    = exc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rsp_d    = rsp_q;
    ReqReady = 1'b0;
    MemValid = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemBE    = 4'b0000;
    MemWData = 32'h0;
    RspValid = 1'b0;
    RspData  = 32'h0;
    RspExc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          we_d    = ReqWe;
          op_d    = ReqOp;
          sgn_d   = ReqSigned;
          addr_d  = ReqAddr;
          wdata_d = ReqWData;
          exc_d   = req_mis;
          rsp_d   = 32'h0;
          state_d = req_mis ? ST_RSP : ST_REQ;
        end
      end
      ST_REQ: begin
        MemValid = 1'b1;
        MemWe    = we_q;
        MemAddr  = {addr_q[ADDR_W-1:2], 2'b00};
        MemBE    = we_q ? st_be : 4'b1111;
        MemWData = we_q ? st_wdata : 32'h0;
        if (MemReady) begin
          state_d = we_q ? ST_RSP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MemRValid) begin
          rsp_d   = ext_data;
          state_d = ST_RSP;
        end
      end
      default: begin
        RspValid = 1'b1;
        RspData  = rsp_q;
        RspExc   = exc_q;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      op_q    <= SZ_WORD;
      sgn_q   <= 1'b0;
      exc_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rsp_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      exc_q   <= exc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// ============================================================================
// Module      : tb_lsu_align
// Description : Scoreboard bench for lsu_align (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, ReqWe, ReqSigned;
  logic [1:0]  ReqOp;
  logic [31:0] ReqAddr, ReqWData;
  logic        MemValid, MemReady, MemWe, MemRValid;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic [3:0]  MemBE;
  logic        RspValid, RspExc;
  logic [31:0] RspData;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } mem_t;

  typedef struct {
    logic [31:0] data;
    logic        exc;
    int          cyc;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t rsp_q[$];

  lsu_align #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWe     (ReqWe),
    .ReqOp     (ReqOp),
    .ReqSigned (ReqSigned),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .MemValid  (MemValid),
    .MemReady  (MemReady),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemBE     (MemBE),
    .MemWData  (MemWData),
    .MemRValid (MemRValid),
    .MemRData  (MemRData),
    .RspValid  (RspValid),
    .RspData   (RspData),
    .RspExc    (RspExc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples one time step after each falling edge.
  initial begin
    mem_t m;
    rsp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (MemValid) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_memvalid", 32'(MemValid), 32'd0);
          end else if (MemReady) begin
            m = mem_q.pop_front();
            chk("mem_addr", MemAddr, m.addr);
            chk("mem_be", 32'(MemBE), 32'(m.be));
            chk("mem_we", 32'(MemWe), 32'(m.we));
            if (m.we) chk("mem_wdata", MemWData, m.wd);
          end
        end
        if (RspValid) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_rspvalid", 32'(RspValid), 32'd0);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_data", RspData, r.data);
            chk("rsp_exc", 32'(RspExc), 32'(r.exc));
            chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
          end
        end
      end
    end
  end

  task automatic do_op(input logic we, input logic [1:0] op, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int d, input logic mem_exp,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic [31:0] e_rsp,
                       input logic e_exc);
    int n;
    int t;
    int lat;
    n = 0;
    @(negedge clk);
    while (!ReqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(ReqReady), 32'd1);
    if (mem_exp) mem_q.push_back('{e_addr, e_be, e_wd, we});
    ReqValid  = 1'b1;
    ReqWe     = we;
    ReqOp     = op;
    ReqSigned = sgn;
    ReqAddr   = addr;
    ReqWData  = wd;
    MemReady  = (d == 0);
    @(posedge clk);
    #1;
    t   = cyc - 1;
    lat = e_exc ? 1 : ((we ? 2 : 3) + d);
    rsp_q.push_back('{e_rsp, e_exc, t + lat});
    @(negedge clk);
    ReqValid = 1'b0;
    if (mem_exp) begin
      for (int i = 0; i < d; i++) begin
        chk("hold_memvalid", 32'(MemValid), 32'd1);
        chk("hold_addr", MemAddr, e_addr);
        chk("hold_be", 32'(MemBE), 32'(e_be));
        if (we) chk("hold_wdata", MemWData, e_wd);
        chk("hold_reqready", 32'(ReqReady), 32'd0);
        @(negedge clk);
      end
      MemReady = 1'b1;
      @(negedge clk);
      MemReady = 1'b0;
      if (!we) begin
        MemRValid = 1'b1;
        MemRData  = rdata;
        @(negedge clk);
        MemRValid = 1'b0;
        MemRData  = 32'h0;
      end
    end
    n = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || mem_q.size() != 0) begin
      chk("timeout_pending", 32'(rsp_q.size() + mem_q.size()), 32'd0);
      rsp_q.delete();
      mem_q.delete();
    end
    MemReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    ReqValid  = 1'b0;
    ReqWe     = 1'b0;
    ReqOp     = 2'b00;
    ReqSigned = 1'b0;
    ReqAddr   = 32'h0;
    ReqWData  = 32'h0;
    MemReady  = 1'b0;
    MemRValid = 1'b0;
    MemRData  = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_memvalid", 32'(MemValid), 32'd0);
    chk("rst_memwe", 32'(MemWe), 32'd0);
    chk("rst_rspvalid", 32'(RspValid), 32'd0);
    chk("rst_rspexc", 32'(RspExc), 32'd0);
    chk("rst_membe", 32'(MemBE), 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memwdata", MemWData, 32'd0);
    chk("rst_rspdata", RspData, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_reqready", 32'(ReqReady), 32'd1);

    // we, op, sgn, addr, wdata, rdata, ready_delay, mem_exp, e_addr, e_be, e_wdata, e_rsp, e_exc
    do_op(1, 2'b10, 0, 32'h1002, 32'h000000A5, 32'h0, 0, 1, 32'h1000, 4'b0100, 32'hA5A5A5A5, 32'h0, 0);
    do_op(0, 2'b01, 1, 32'h2002, 32'h0, 32'h80017FFF, 0, 1, 32'h2000, 4'b1111, 32'h0, 32'hFFFF8001, 0);
    do_op(0, 2'b01, 0, 32'h2002, 32'h0, 32'h80017FFF, 0, 1, 32'h2000, 4'b1111, 32'h0, 32'h00008001, 0);
    do_op(0, 2'b10, 1, 32'h3001, 32'h0, 32'h00008000, 0, 1, 32'h3000, 4'b1111, 32'h0, 32'hFFFFFF80, 0);
    do_op(1, 2'b01, 0, 32'h5002, 32'hDEAD1234, 32'h0, 0, 1, 32'h5000, 4'b1100, 32'h12341234, 32'h0, 0);
    do_op(1, 2'b00, 0, 32'h600C, 32'hCAFEBABE, 32'h0, 5, 1, 32'h600C, 4'b1111, 32'hCAFEBABE, 32'h0, 0);
    do_op(0, 2'b10, 0, 32'h7003, 32'h0, 32'hF2345678, 0, 1, 32'h7000, 4'b1111, 32'h0, 32'h000000F2, 0);
    do_op(0, 2'b00, 1, 32'h8000, 32'h0, 32'h89ABCDEF, 0, 1, 32'h8000, 4'b1111, 32'h0, 32'h89ABCDEF, 0);
    do_op(1, 2'b10, 0, 32'h9000, 32'h1234567F, 32'h0, 0, 1, 32'h9000, 4'b0001, 32'h7F7F7F7F, 32'h0, 0);
    do_op(0, 2'b01, 0, 32'hA000, 32'h0, 32'h1234ABCD, 2, 1, 32'hA000, 4'b1111, 32'h0, 32'h0000ABCD, 0);
    do_op(0, 2'b01, 1, 32'hA000, 32'h0, 32'h1234ABCD, 0, 1, 32'hA000, 4'b1111, 32'h0, 32'hFFFFABCD, 0);
    do_op(0, 2'b11, 1, 32'hB000, 32'h0, 32'h55667788, 0, 1, 32'hB000, 4'b1111, 32'h0, 32'h55667788, 0);
    do_op(1, 2'b01, 0, 32'hE000, 32'h0000BEEF, 32'h0, 3, 1, 32'hE000, 4'b0011, 32'hBEEFBEEF, 32'h0, 0);
`ifdef LSU_ADDR_EXC_EN
    do_op(0, 2'b00, 0, 32'h4001, 32'h0, 32'h11223344, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
    do_op(0, 2'b01, 1, 32'hC003, 32'h0, 32'hAABBCCDD, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
`else
    do_op(0, 2'b00, 0, 32'h4001, 32'h0, 32'h11223344, 0, 1, 32'h4000, 4'b1111, 32'h0, 32'h11223344, 0);
    do_op(0, 2'b01, 1, 32'hC003, 32'h0, 32'hAABBCCDD, 0, 1, 32'hC000, 4'b1111, 32'h0, 32'hFFFFAABB, 0);
`endif

    // Reset while waiting for read data: the transaction must vanish.
    @(negedge clk);
    mem_q.push_back('{32'hD000, 4'b1111, 32'h0, 1'b0});
    ReqValid  = 1'b1;
    ReqWe     = 1'b0;
    ReqOp     = 2'b00;
    ReqSigned = 1'b0;
    ReqAddr   = 32'hD000;
    MemReady  = 1'b1;
    @(negedge clk);
    ReqValid = 1'b0;
    @(negedge clk);
    MemReady = 1'b0;
    chk("wait_reqready", 32'(ReqReady), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    MemRValid = 1'b1;
    MemRData  = 32'h12345678;
    @(negedge clk);
    MemRValid = 1'b0;
    MemRData  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_rspvalid", 32'(RspValid), 32'd0);
      chk("post_reset_reqready", 32'(ReqReady), 32'd1);
      @(negedge clk);
    end
    chk("post_reset_memq", 32'(mem_q.size()), 32'd0);

    // Normal operation resumes after the abandoned transaction.
    do_op(0, 2'b10, 1, 32'hF002, 32'h0, 32'h007F0000, 0, 1, 32'hF000, 4'b1111, 32'h0, 32'h0000007F, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
